pix_rd_arbiter: RTL and testbench

PIX_RD_ARBITER -- requirements
Module: pix_rd_arbiter

---
 rtl/pix_rd_arbiter_pkg.sv | 30 +++
 rtl/pix_rd_arbiter_address_translator.sv | 37 +++
 rtl/pix_rd_arbiter.sv | 174 +++++++++++++++++
 tb/tb_pix_rd_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pix_rd_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// pix_rd_arbiter_pkg
// Shared constants and types for the pixel read arbiter and its address
// translator: default requester count, image geometry, coordinate/address/pixel
// widths, requester index names and the arbiter FSM state encoding.
// -----------------------------------------------------------------------------
package pix_rd_arbiter_pkg;

    localparam int NREQ_DEF  = 3;
    localparam int IMG_W_DEF = 60;
    localparam int COORD_W   = 6;
    localparam int ADDR_W    = 12;
    localparam int PIX_W     = 3;

    // Requester slots on the shared image RAM.
    localparam int REQ_TB_MAPPER = 0;
    localparam int REQ_R_FINDER  = 1;
    localparam int REQ_L_FINDER  = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RD   = 1'b1
    } arbState_t;

    // Width of a round-robin pointer; kept at least one bit wide.
    function automatic int ptrWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pix_rd_arbiter_address_translator.sv
// -----------------------------------------------------------------------------
// address_translator
// Maps an (x, y) pixel coordinate to a linear RAM address y*IMG_W + x.
// The multiply by the constant IMG_W is unrolled into shifted copies of y,
// one per set bit of IMG_W, so no multiplier is inferred.
//
// Ports:
//   x    in  COORD_W  column
//   y    in  COORD_W  row
//   addr out ADDR_W   linear address (unchecked, wraps modulo 2**ADDR_W)
// -----------------------------------------------------------------------------
module address_translator
    import pix_rd_arbiter_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [ADDR_W-1:0]  addr
);

    localparam logic [ADDR_W-1:0] W_BITS = ADDR_W'(IMG_W);

    logic [ADDR_W-1:0] yExt;

    assign yExt = ADDR_W'(y);

    always_comb begin
        addr = ADDR_W'(x);
        for (int k = 0; k < ADDR_W; k++) begin
            if (W_BITS[k]) begin
                addr = addr + (yExt << k);
            end
        end
    end

endmodule

// File: rtl/pix_rd_arbiter.sv
// -----------------------------------------------------------------------------
// pix_rd_arbiter
// Round-robin arbiter giving NREQ requesters single-cycle access to a shared
// read-only image RAM. A grant is combinational in the cycle the request is
// accepted; the RAM answers one cycle later and the data is returned with a
// one-hot rvalid. Grants may issue every cycle.
//
// Optional feature (macro PIX_ARB_BOUNDS_CHK_EN): coordinate bounds checking.
// When defined, an out-of-range coordinate yields ram_addr=0 and a returned
// pixel of 0 flagged on the err output.
//
// Ports:
//   clk       in   clock
//   reset     in   synchronous active-high reset
//   req       in   NREQ       read requests, held until granted
//   x_in      in   NREQ*6     packed x coordinates, requester i at [6i+5:6i]
//   y_in      in   NREQ*6     packed y coordinates
//   freeze    in   blocks new grants
//   gnt       out  NREQ       one-hot grant (combinational)
//   rvalid    out  NREQ       one-hot read-data valid
//   rdata     out  3          pixel value
//   ram_addr  out  12         RAM read address
//   ram_q     in   3          RAM data, one cycle after ram_addr
//   busy      out  read in flight
//   err       out  NREQ       out-of-range flag (PIX_ARB_BOUNDS_CHK_EN only)
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no read in flight; rvalid low
// ST_RD   | a read was granted last cycle; rvalid/rdata present this cycle
// -----------------------------------------------------------------------------
module pix_rd_arbiter
    import pix_rd_arbiter_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int IMG_W = IMG_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*COORD_W-1:0] x_in,
    input  logic [NREQ*COORD_W-1:0] y_in,
    input  logic                    freeze,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         rvalid,
    output logic [PIX_W-1:0]        rdata,
    output logic [ADDR_W-1:0]       ram_addr,
    input  logic [PIX_W-1:0]        ram_q,
`ifdef PIX_ARB_BOUNDS_CHK_EN
    output logic [NREQ-1:0]         err,
`endif
    output logic                    busy
);

    localparam int PTR_W = ptrWidth(NREQ);

    arbState_t         state, nextState;
    logic [PTR_W-1:0]  rrPtr, nextPtr;
    logic [PTR_W-1:0]  pickIdx, cand;
    logic              found;
    logic              anyGnt;
    logic [NREQ-1:0]   rdMask;
    logic [COORD_W-1:0] selX, selY;
    logic [ADDR_W-1:0] xlatAddr;
    logic              oob;
    logic              oobQ;

    // Round-robin search starting at rrPtr.
    always_comb begin
        pickIdx = '0;
        cand    = '0;
        found   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PTR_W'((int'(rrPtr) + k) % NREQ);
            if (!found && req[cand]) begin
                found   = 1'b1;
                pickIdx = cand;
            end
        end
    end

    // Reset gates the grant combinationally so nothing is issued in the
    // cycle the reset is applied.
    assign anyGnt = found && !freeze && !reset;

    always_comb begin
        gnt = '0;
        if (anyGnt) begin
            gnt[pickIdx] = 1'b1;
        end
    end

    assign nextPtr = (int'(pickIdx) == NREQ - 1) ? '0 : pickIdx + 1'b1;

    always_comb begin
        selX = '0;
        selY = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (pickIdx == PTR_W'(k)) begin
                selX = x_in[k*COORD_W +: COORD_W];
                selY = y_in[k*COORD_W +: COORD_W];
            end
        end
    end

    address_translator #(
        .IMG_W (IMG_W)
    ) uXlat (
        .x    (selX),
        .y    (selY),
        .addr (xlatAddr)
    );

`ifdef PIX_ARB_BOUNDS_CHK_EN
    localparam logic [COORD_W:0] IMG_W_C = (COORD_W + 1)'(IMG_W);
    assign oob = ({1'b0, selX} >= IMG_W_C) || ({1'b0, selY} >= IMG_W_C);
`else
    assign oob = 1'b0;
`endif

    always_comb begin
        ram_addr = '0;
        if (anyGnt && !oob) begin
            ram_addr = xlatAddr;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: if (anyGnt)  nextState = ST_RD;
            ST_RD:   if (!anyGnt) nextState = ST_IDLE;
            default: nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            rrPtr  <= '0;
            rdMask <= '0;
            oobQ   <= 1'b0;
        end else begin
            state  <= nextState;
            rdMask <= gnt;
            oobQ   <= anyGnt && oob;
            if (anyGnt) begin
                rrPtr <= nextPtr;
            end
        end
    end

    // A reset arriving while a read is in flight drops its result.
    always_comb begin
        rvalid = '0;
        if (state == ST_RD && !reset) begin
            rvalid = rdMask;
        end
    end

    always_comb begin
        rdata = '0;
        if ((|rvalid) && !oobQ) begin
            rdata = ram_q;
        end
    end

`ifdef PIX_ARB_BOUNDS_CHK_EN
    assign err = oobQ ? rvalid : '0;
`endif

    assign busy = (state == ST_RD);

endmodule

// File: tb/tb_pix_rd_arbiter.sv
module tb_pix_rd_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req;
    logic [17:0] x_in;
    logic [17:0] y_in;
    logic        freeze;
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [2:0]  rdata;
    logic [11:0] ram_addr;
    logic [2:0]  ram_q;
    logic        busy;
`ifdef PIX_ARB_BOUNDS_CHK_EN
    logic [2:0]  err;
`endif

    int nChecks = 0;
    int nFail   = 0;

    pix_rd_arbiter #(.NREQ(3), .IMG_W(60)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .x_in     (x_in),
        .y_in     (y_in),
        .freeze   (freeze),
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .ram_addr (ram_addr),
        .ram_q    (ram_q),
`ifdef PIX_ARB_BOUNDS_CHK_EN
        .err      (err),
`endif
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Image RAM model: content is a fixed scramble of the address.
    function automatic logic [2:0] pix(input logic [11:0] a);
        return a[2:0] ^ a[5:3] ^ a[8:6] ^ a[11:9] ^ 3'd5;
    endfunction

    always @(posedge clk) ram_q <= pix(ram_addr);

    task automatic check(input string name, input int row, input logic [11:0] act,
                         input logic [11:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        frz;
        logic [2:0]  req;
        logic [17:0] x;
        logic [17:0] y;
        logic [2:0]  expGnt;
        logic [11:0] expAddr;
        logic [2:0]  expRvalid;
        logic        expBusy;
        logic        chkBusy;
        logic        expErr;
    } vec_t;

    localparam logic [17:0] XD = {6'd3, 6'd5, 6'd1};
    localparam logic [17:0] YD = {6'd59, 6'd2, 6'd0};
    localparam logic [17:0] XO = {6'd3, 6'd5, 6'd60};
    // Addresses for the default coordinates: r0=1, r1=2*60+5=125, r2=59*60+3=3543
    localparam logic [11:0] A0 = 12'd1;
    localparam logic [11:0] A1 = 12'd125;
    localparam logic [11:0] A2 = 12'd3543;
`ifdef PIX_ARB_BOUNDS_CHK_EN
    localparam logic [11:0] AO = 12'd0;
    localparam logic        EO = 1'b1;
`else
    localparam logic [11:0] AO = 12'd60;
    localparam logic        EO = 1'b0;
`endif

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic frz, input logic [2:0] rq,
                                input logic [17:0] x, input logic [2:0] eg,
                                input logic [11:0] ea, input logic [2:0] ev,
                                input logic eb, input logic cb, input logic ee);
        vec_t v;
        v.rst = rst; v.frz = frz; v.req = rq; v.x = x; v.y = YD;
        v.expGnt = eg; v.expAddr = ea; v.expRvalid = ev;
        v.expBusy = eb; v.chkBusy = cb; v.expErr = ee;
        return v;
    endfunction

    logic [11:0] prevAddr;
    logic [2:0]  expRdata;

    initial begin
        reset = 1'b1; req = '0; x_in = XD; y_in = YD; freeze = 1'b0;
        repeat (2) @(posedge clk);

        //            rst frz req    x   gnt    addr rvalid busy chk err
        vecs.push_back(mk(1, 0, 3'b111, XD, 3'b000, 0,  3'b000, 0, 1, 0)); // reset gates grant
        vecs.push_back(mk(0, 0, 3'b010, XD, 3'b010, A1, 3'b000, 0, 1, 0)); // single request r1
        vecs.push_back(mk(0, 0, 3'b000, XD, 3'b000, 0,  3'b010, 1, 1, 0));
        vecs.push_back(mk(0, 0, 3'b000, XD, 3'b000, 0,  3'b000, 0, 1, 0));
        vecs.push_back(mk(1, 0, 3'b000, XD, 3'b000, 0,  3'b000, 0, 1, 0)); // rrPtr back to 0
        vecs.push_back(mk(0, 0, 3'b111, XD, 3'b001, A0, 3'b000, 0, 1, 0)); // rotation 0,1,2,0,1,2
        vecs.push_back(mk(0, 0, 3'b111, XD, 3'b010, A1, 3'b001, 1, 1, 0));
        vecs.push_back(mk(0, 0, 3'b111, XD, 3'b100, A2, 3'b010, 1, 1, 0));
        vecs.push_back(mk(0, 0, 3'b111, XD, 3'b001, A0, 3'b100, 1, 1, 0));
        vecs.push_back(mk(0, 0, 3'b111, XD, 3'b010, A1, 3'b001, 1, 1, 0));
        vecs.push_back(mk(0, 0, 3'b111, XD, 3'b100, A2, 3'b010, 1, 1, 0));
        vecs.push_back(mk(0, 0, 3'b000, XD, 3'b000, 0,  3'b100, 1, 1, 0));
        vecs.push_back(mk(0, 0, 3'b000, XD, 3'b000, 0,  3'b000, 0, 1, 0));
        vecs.push_back(mk(0, 1, 3'b001, XD, 3'b000, 0,  3'b000, 0, 1, 0)); // freeze holds off r0
        vecs.push_back(mk(0, 1, 3'b001, XD, 3'b000, 0,  3'b000, 0, 1, 0));
        vecs.push_back(mk(0, 1, 3'b001, XD, 3'b000, 0,  3'b000, 0, 1, 0));
        vecs.push_back(mk(0, 0, 3'b001, XD, 3'b001, A0, 3'b000, 0, 1, 0));
        vecs.push_back(mk(0, 0, 3'b000, XD, 3'b000, 0,  3'b001, 1, 1, 0));
        vecs.push_back(mk(0, 0, 3'b000, XD, 3'b000, 0,  3'b000, 0, 1, 0));
        vecs.push_back(mk(0, 0, 3'b100, XD, 3'b100, A2, 3'b000, 0, 1, 0)); // lone r2 held 4 cycles
        vecs.push_back(mk(0, 0, 3'b100, XD, 3'b100, A2, 3'b100, 1, 1, 0));
        vecs.push_back(mk(0, 0, 3'b100, XD, 3'b100, A2, 3'b100, 1, 1, 0));
        vecs.push_back(mk(0, 0, 3'b100, XD, 3'b100, A2, 3'b100, 1, 1, 0));
        vecs.push_back(mk(0, 0, 3'b000, XD, 3'b000, 0,  3'b100, 1, 1, 0));
        vecs.push_back(mk(0, 0, 3'b000, XD, 3'b000, 0,  3'b000, 0, 1, 0));
        vecs.push_back(mk(0, 0, 3'b100, XD, 3'b100, A2, 3'b000, 0, 1, 0)); // grant r2 then reset
        vecs.push_back(mk(1, 0, 3'b100, XD, 3'b000, 0,  3'b000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 3'b000, XD, 3'b000, 0,  3'b000, 0, 1, 0));
        vecs.push_back(mk(0, 0, 3'b111, XD, 3'b001, A0, 3'b000, 0, 1, 0));
        vecs.push_back(mk(0, 0, 3'b000, XD, 3'b000, 0,  3'b001, 1, 1, 0));
        vecs.push_back(mk(0, 0, 3'b000, XD, 3'b000, 0,  3'b000, 0, 1, 0));
        vecs.push_back(mk(0, 0, 3'b010, XD, 3'b010, A1, 3'b000, 0, 1, 0)); // freeze during read
        vecs.push_back(mk(0, 1, 3'b010, XD, 3'b000, 0,  3'b010, 1, 1, 0));
        vecs.push_back(mk(0, 0, 3'b010, XD, 3'b010, A1, 3'b000, 0, 1, 0));
        vecs.push_back(mk(0, 0, 3'b000, XD, 3'b000, 0,  3'b010, 1, 1, 0));
        vecs.push_back(mk(0, 0, 3'b000, XD, 3'b000, 0,  3'b000, 0, 1, 0));
        vecs.push_back(mk(0, 0, 3'b001, XO, 3'b001, AO, 3'b000, 0, 1, 0)); // x0=60 out of range
        vecs.push_back(mk(0, 0, 3'b000, XD, 3'b000, 0,  3'b001, 1, 1, EO));
        vecs.push_back(mk(0, 0, 3'b000, XD, 3'b000, 0,  3'b000, 0, 1, 0));

        prevAddr = '0;
        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            reset = vecs[i].rst; freeze = vecs[i].frz; req = vecs[i].req;
            x_in = vecs[i].x; y_in = vecs[i].y;
            @(negedge clk);
            expRdata = (vecs[i].expRvalid != 3'b000 && !vecs[i].expErr) ? pix(prevAddr) : 3'd0;
            check("gnt",      i, 12'(gnt),      12'(vecs[i].expGnt));
            check("ram_addr", i, ram_addr,      vecs[i].expAddr);
            check("rvalid",   i, 12'(rvalid),   12'(vecs[i].expRvalid));
            check("rdata",    i, 12'(rdata),    12'(expRdata));
            if (vecs[i].chkBusy) check("busy", i, 12'(busy), 12'(vecs[i].expBusy));
`ifdef PIX_ARB_BOUNDS_CHK_EN
            check("err", i, 12'(err), vecs[i].expErr ? 12'(vecs[i].expRvalid) : 12'd0);
`endif
            prevAddr = vecs[i].expAddr;
        end

        // Lone requester walking its coordinate every cycle: address and
        // returned pixel track the update with one cycle of latency.
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            reset = 1'b0; freeze = 1'b0;
            req  = (k < 3) ? 3'b001 : 3'b000;
            x_in = {6'd3, 6'd5, 6'(k)};
            y_in = {6'd59, 6'd2, 6'd1};
            @(negedge clk);
            if (k < 3) begin
                check("walk_gnt",  100 + k, 12'(gnt), 12'd1);
                check("walk_addr", 100 + k, ram_addr, 12'(60 + k));
            end
            if (k > 0) begin
                check("walk_rvalid", 100 + k, 12'(rvalid), 12'd1);
                check("walk_rdata",  100 + k, 12'(rdata),  12'(pix(12'(60 + k - 1))));
            end
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        check("walk_idle_busy", 104, 12'(busy), 12'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
